sobel_window_rx: RTL and testbench

- Receiving end of the grey-scale pixel stream that the image reader emits as raster-order (rowIndex, colIndex, DATA_R0).
- Buffers two image lines and presents a registered 3x3 neighbourhood plus its centre coordinates to the Sobel arithmetic, using a valid/ready handshake.
- Checks the incoming indices against its own raster counters, so framing slips are flagged rather than silently corrupting the edge map.

---
 rtl/image_pkg.sv | 24 ++
 rtl/sobel_line_buffer.sv | 27 ++
 rtl/sobel_window_rx.sv | 192 +++++++++++++++++++
 tb/tb_sobel_window_rx.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared image-pipeline definitions: default geometry and the win_data lane layout
// used by the window receiver, the Sobel arithmetic and the grey-scale reader.
package image_pkg;

   localparam int DEF_BITS_FOR_INDEX = 10;
   localparam int DEF_DATA_W         = 8;
   localparam int DEF_IMG_WIDTH      = 640;
   localparam int DEF_IMG_HEIGHT     = 480;

   localparam int WIN_ROWS  = 3;
   localparam int WIN_COLS  = 3;
   localparam int WIN_LANES = WIN_ROWS * WIN_COLS;

   // Row numbers inside the window (top = two lines back, bottom = current line).
   localparam int ROW_TOP = 0;
   localparam int ROW_MID = 1;
   localparam int ROW_BOT = 2;

   // Lane of p[r][c] inside win_data: row-major, p00 in lane 0 (LSBs).
   function automatic int win_lane(input int r, input int c);
      return (r * WIN_COLS) + c;
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixels: combinational read, synchronous write, no reset
// (contents are always rewritten before a window depends on them).
module sobel_line_buffer #(
   parameter int DEPTH  = 640,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [DEPTH];

   // Read-before-write: rdata shows the old contents during the write cycle.
   assign rdata = mem_r[addr];

   // Pixel storage write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= wdata;
      end
   end

endmodule

// File: rtl/sobel_window_rx.sv
// Raster pixel receiver: checks incoming indices, keeps two line buffers and a
// 3x3 shift window, and hands registered neighbourhoods downstream with valid/ready.
module sobel_window_rx
   import image_pkg::*;
#(
   parameter int BITS_FOR_INDEX = DEF_BITS_FOR_INDEX,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int IMG_WIDTH      = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT     = DEF_IMG_HEIGHT
) (
   input  logic                          HCLK,
   input  logic                          HRESETn,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [BITS_FOR_INDEX-1:0]     rowIndex,
   input  logic [BITS_FOR_INDEX-1:0]     colIndex,
   input  logic [DATA_W-1:0]             DATA_R0,
   output logic                          win_valid,
   input  logic                          win_ready,
   output logic [WIN_LANES*DATA_W-1:0]   win_data,
   output logic [BITS_FOR_INDEX-1:0]     win_row,
   output logic [BITS_FOR_INDEX-1:0]     win_col,
   output logic                          frame_done,
   output logic                          sync_err
);

   localparam int ADDR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

   localparam logic [BITS_FOR_INDEX-1:0] IDX_ZERO = BITS_FOR_INDEX'(0);
   localparam logic [BITS_FOR_INDEX-1:0] IDX_ONE  = BITS_FOR_INDEX'(1);
   localparam logic [BITS_FOR_INDEX-1:0] IDX_TWO  = BITS_FOR_INDEX'(2);
   localparam logic [BITS_FOR_INDEX-1:0] LAST_COL = BITS_FOR_INDEX'(IMG_WIDTH - 1);
   localparam logic [BITS_FOR_INDEX-1:0] LAST_ROW = BITS_FOR_INDEX'(IMG_HEIGHT - 1);
   localparam logic [BITS_FOR_INDEX-1:0] FD_ROW   = BITS_FOR_INDEX'(IMG_HEIGHT - 2);
   localparam logic [BITS_FOR_INDEX-1:0] FD_COL   = BITS_FOR_INDEX'(IMG_WIDTH - 2);

   logic                          in_ready_s;
   logic                          accept_s;
   logic                          idx_match_s;
   logic                          restart_s;
   logic                          proc_s;
   logic                          err_s;
   logic                          emit_s;

   logic [ADDR_W-1:0]             lb_addr_s;
   logic [DATA_W-1:0]             lb0_rd_s;
   logic [DATA_W-1:0]             lb1_rd_s;

   logic [BITS_FOR_INDEX-1:0]     exp_row_r;
   logic [BITS_FOR_INDEX-1:0]     exp_col_r;

   logic [DATA_W-1:0]             win_sh_r   [WIN_ROWS][WIN_COLS];
   logic [DATA_W-1:0]             win_next_s [WIN_ROWS][WIN_COLS];
   logic [WIN_LANES*DATA_W-1:0]   win_pack_s;

   logic                          win_valid_r;
   logic [WIN_LANES*DATA_W-1:0]   win_data_r;
   logic [BITS_FOR_INDEX-1:0]     win_row_r;
   logic [BITS_FOR_INDEX-1:0]     win_col_r;
   logic                          frame_done_r;
   logic                          sync_err_r;

   // Handshake and raster-position classification of the offered pixel.
   always_comb begin
      in_ready_s  = !win_valid_r || win_ready;
      accept_s    = in_valid && in_ready_s;
      idx_match_s = (rowIndex == exp_row_r) && (colIndex == exp_col_r);
      // A (0,0) that arrives out of turn is taken as the start of a fresh frame.
      restart_s   = !idx_match_s && (rowIndex == IDX_ZERO) && (colIndex == IDX_ZERO);
      proc_s      = accept_s && (idx_match_s || restart_s);
      err_s       = accept_s && !idx_match_s && !restart_s;
      emit_s      = proc_s && (rowIndex >= IDX_TWO) && (colIndex >= IDX_TWO);
   end

   assign lb_addr_s = colIndex[ADDR_W-1:0];

   // lb1 holds row r-1, lb0 holds row r-2; each accepted pixel ages its column by one line.
   sobel_line_buffer #(
      .DEPTH  (IMG_WIDTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) lb0 (
      .clk   (HCLK),
      .we    (proc_s),
      .addr  (lb_addr_s),
      .wdata (lb1_rd_s),
      .rdata (lb0_rd_s)
   );

   sobel_line_buffer #(
      .DEPTH  (IMG_WIDTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) lb1 (
      .clk   (HCLK),
      .we    (proc_s),
      .addr  (lb_addr_s),
      .wdata (DATA_R0),
      .rdata (lb1_rd_s)
   );

   // Next window after a left shift, with the new column entering on the right.
   always_comb begin
      win_next_s = '{default: '0};
      win_pack_s = '0;
      for (int r = 0; r < WIN_ROWS; r++) begin
         for (int c = 0; c < WIN_COLS; c++) begin
            if (c < WIN_COLS - 1) begin
               win_next_s[r][c] = win_sh_r[r][c+1];
            end else begin
               case (r)
                  ROW_TOP: win_next_s[r][c] = lb0_rd_s;
                  ROW_MID: win_next_s[r][c] = lb1_rd_s;
                  default: win_next_s[r][c] = DATA_R0;
               endcase
            end
            win_pack_s[win_lane(r, c)*DATA_W +: DATA_W] = win_next_s[r][c];
         end
      end
   end

   // Expected raster position; wraps at line and frame ends.
   always_ff @(posedge HCLK) begin
      if (HRESETn) begin
         exp_row_r <= IDX_ZERO;
         exp_col_r <= IDX_ZERO;
      end else if (proc_s) begin
         if (colIndex == LAST_COL) begin
            exp_col_r <= IDX_ZERO;
            exp_row_r <= (rowIndex == LAST_ROW) ? IDX_ZERO : (rowIndex + IDX_ONE);
         end else begin
            exp_col_r <= colIndex + IDX_ONE;
            exp_row_r <= rowIndex;
         end
      end else begin
         exp_row_r <= exp_row_r;
         exp_col_r <= exp_col_r;
      end
   end

   // 3x3 shift window, advanced once per processed pixel.
   always_ff @(posedge HCLK) begin
      if (HRESETn) begin
         win_sh_r <= '{default: '0};
      end else if (proc_s) begin
         win_sh_r <= win_next_s;
      end else begin
         win_sh_r <= win_sh_r;
      end
   end

   // Output window register plus the one-cycle status pulses.
   always_ff @(posedge HCLK) begin
      if (HRESETn) begin
         win_valid_r  <= 1'b0;
         win_data_r   <= '0;
         win_row_r    <= IDX_ZERO;
         win_col_r    <= IDX_ZERO;
         frame_done_r <= 1'b0;
         sync_err_r   <= 1'b0;
      end else begin
         // Loading is only possible when the old window is gone or leaving this cycle.
         if (emit_s) begin
            win_valid_r <= 1'b1;
            win_data_r  <= win_pack_s;
            win_row_r   <= rowIndex - IDX_ONE;
            win_col_r   <= colIndex - IDX_ONE;
         end else if (win_valid_r && win_ready) begin
            win_valid_r <= 1'b0;
            win_data_r  <= '0;
            win_row_r   <= IDX_ZERO;
            win_col_r   <= IDX_ZERO;
         end else begin
            win_valid_r <= win_valid_r;
            win_data_r  <= win_data_r;
            win_row_r   <= win_row_r;
            win_col_r   <= win_col_r;
         end
         frame_done_r <= win_valid_r && win_ready && (win_row_r == FD_ROW) && (win_col_r == FD_COL);
         sync_err_r   <= err_s;
      end
   end

   assign in_ready   = in_ready_s;
   assign win_valid  = win_valid_r;
   assign win_data   = win_data_r;
   assign win_row    = win_row_r;
   assign win_col    = win_col_r;
   assign frame_done = frame_done_r;
   assign sync_err   = sync_err_r;

endmodule

// File: tb/tb_sobel_window_rx.sv
// Randomised scenario bench for sobel_window_rx on a 5x4 image, checked against
// a frame-array reference model of the raster/window rules.
module tb_sobel_window_rx;

   localparam int BI = 10;
   localparam int DW = 8;
   localparam int W  = 5;
   localparam int H  = 4;

   logic            HCLK;
   logic            HRESETn;
   logic            in_valid;
   logic            in_ready;
   logic [BI-1:0]   rowIndex;
   logic [BI-1:0]   colIndex;
   logic [DW-1:0]   DATA_R0;
   logic            win_valid;
   logic            win_ready;
   logic [9*DW-1:0] win_data;
   logic [BI-1:0]   win_row;
   logic [BI-1:0]   win_col;
   logic            frame_done;
   logic            sync_err;

   sobel_window_rx #(
      .BITS_FOR_INDEX (BI),
      .DATA_W         (DW),
      .IMG_WIDTH      (W),
      .IMG_HEIGHT     (H)
   ) dut (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .rowIndex   (rowIndex),
      .colIndex   (colIndex),
      .DATA_R0    (DATA_R0),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_data   (win_data),
      .win_row    (win_row),
      .win_col    (win_col),
      .frame_done (frame_done),
      .sync_err   (sync_err)
   );

   typedef struct packed {
      logic [9*DW-1:0] data;
      logic [BI-1:0]   row;
      logic [BI-1:0]   col;
   } win_t;

   int   errors = 0;
   int   checks = 0;
   win_t exp_q[$];
   win_t obs_q[$];
   int   fd_obs, se_obs, fd_exp, se_exp;
   int   img [H][W];
   int   m_r, m_c;
   int   rdy_mode;   // 0: always ready, 1: random, 2: hold low

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   initial begin
      win_ready = 1'b1;
      forever begin
         @(posedge HCLK);
         #1;
         case (rdy_mode)
            0:       win_ready = 1'b1;
            1:       win_ready = 1'($urandom_range(0, 1));
            default: win_ready = 1'b0;
         endcase
      end
   end

   // Record every consumed window and every status pulse.
   initial begin
      forever begin
         @(negedge HCLK);
         if (win_valid && win_ready) obs_q.push_back('{data: win_data, row: win_row, col: win_col});
         if (frame_done) fd_obs++;
         if (sync_err) se_obs++;
      end
   end

   // ---------------- reference model ----------------
   function automatic win_t model_win(int cr, int cc);
      win_t w;
      logic [31:0] v;
      w.data = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            v = img[cr-1+i][cc-1+j];
            w.data[(i*3+j)*DW +: DW] = v[DW-1:0];
         end
      w.row = BI'(cr);
      w.col = BI'(cc);
      return w;
   endfunction

   task automatic model_accept(int r, int c, int d);
      if ((r == m_r && c == m_c) || (r == 0 && c == 0)) begin
         img[r][c] = d;
         if (r >= 2 && c >= 2) begin
            exp_q.push_back(model_win(r-1, c-1));
            if (r-1 == H-2 && c-1 == W-2) fd_exp++;
         end
         if (c == W-1) begin
            m_c = 0;
            m_r = (r == H-1) ? 0 : r + 1;
         end else begin
            m_c = c + 1;
            m_r = r;
         end
      end else begin
         se_exp++;
      end
   endtask

   function automatic int first_bad();
      int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
      if (obs_q.size() != exp_q.size()) return n;
      return -1;
   endfunction

   task automatic new_scenario();
      exp_q.delete();
      obs_q.delete();
      fd_obs = 0; se_obs = 0; fd_exp = 0; se_exp = 0;
   endtask

   // ---------------- drivers ----------------
   task automatic send(int r, int c, int d);
      bit acc = 1'b0;
      int tries = 0;
      in_valid = 1'b1;
      rowIndex = BI'(r);
      colIndex = BI'(c);
      DATA_R0  = DW'(d);
      do begin
         @(negedge HCLK);
         acc = in_ready;
         @(posedge HCLK);
         #1;
         tries++;
      end while (!acc && tries < 200);
      in_valid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL accept_timeout: pixel (%0d,%0d) got in_ready=0 for %0d cycles, want accept", r, c, tries);
      end else begin
         model_accept(r, c, d);
      end
   endtask

   task automatic send_range(int r0, int c0, int r1, int c1, bit rnd);
      for (int k = r0*W + c0; k <= r1*W + c1; k++)
         send(k / W, k % W, rnd ? int'($urandom_range(0, 255)) : 10*(k / W) + (k % W));
   endtask

   task automatic drain(output bit ok);
      rdy_mode  = 0;
      win_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge HCLK);
         if (!win_valid) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (2) @(posedge HCLK);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      HRESETn  = 1'b1;
      @(posedge HCLK);
      #1;
      HRESETn  = 1'b0;
      m_r = 0;
      m_c = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rowIndex = '0; colIndex = '0; DATA_R0 = '0; in_valid = 1'b0; rdy_mode = 0;
      HRESETn = 1'b1;
      repeat (2) @(posedge HCLK);
      #1;
      HRESETn = 1'b0;
      m_r = 0; m_c = 0;
      checks++;
      if (win_valid !== 1'b0 || win_data !== '0 || win_row !== '0 || win_col !== '0) begin
         errors++;
         $display("FAIL reset_window: got v=%b d=%h r=%0d c=%0d, want all 0", win_valid, win_data, win_row, win_col);
      end
      checks++;
      if (frame_done !== 1'b0 || sync_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_pulses: got fd=%b se=%b, want 0 0", frame_done, sync_err);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, want 1", in_ready);
      end
   endtask

   task automatic test_full_frame();
      bit ok;
      int bad;
      new_scenario();
      send_range(0, 0, 2, 1, 1'b0);
      checks++;
      if (win_valid !== 1'b0) begin
         errors++;
         $display("FAIL border_no_window: got win_valid=%b, want 0", win_valid);
      end
      send(2, 2, 22);
      checks++;
      if (win_valid !== 1'b1 || win_row !== BI'(1) || win_col !== BI'(1)) begin
         errors++;
         $display("FAIL first_window_pos: got v=%b (%0d,%0d), want 1 (1,1)", win_valid, win_row, win_col);
      end
      checks++;
      if (win_data !== 72'h16_15_14_0C_0B_0A_02_01_00) begin
         errors++;
         $display("FAIL first_window_data: got %h, want 161514_0c0b0a_020100", win_data);
      end
      send_range(2, 3, 3, 4, 1'b0);
      drain(ok);
      bad = first_bad();
      checks++;
      if (!ok || obs_q.size() != 6) begin
         errors++;
         $display("FAIL full_count: got %0d windows (drained=%b), want 6", obs_q.size(), ok);
      end
      checks++;
      if (bad != -1) begin
         errors++;
         $display("FAIL full_windows: got first mismatch at index %0d, want none", bad);
      end
      checks++;
      if (fd_obs != 1 || se_obs != 0) begin
         errors++;
         $display("FAIL full_pulses: got fd=%0d se=%0d, want 1 0", fd_obs, se_obs);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int bad;
      new_scenario();
      send_range(0, 0, 2, 2, 1'b0);
      rdy_mode  = 2;
      win_ready = 1'b0;
      in_valid  = 1'b1;
      rowIndex  = BI'(2);
      colIndex  = BI'(3);
      DATA_R0   = DW'(23);
      for (int i = 0; i < 3; i++) begin
         @(negedge HCLK);
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready: cycle %0d got %b, want 0", i, in_ready);
         end
         checks++;
         if (win_valid !== 1'b1 || win_data !== exp_q[0].data || win_row !== BI'(1) || win_col !== BI'(1)) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d got v=%b d=%h (%0d,%0d), want 1 %h (1,1)",
                     i, win_valid, win_data, win_row, win_col, exp_q[0].data);
         end
         @(posedge HCLK);
         #1;
      end
      rdy_mode  = 0;
      win_ready = 1'b1;
      send_range(2, 3, 3, 4, 1'b0);
      drain(ok);
      bad = first_bad();
      checks++;
      if (!ok || bad != -1 || obs_q.size() != 6) begin
         errors++;
         $display("FAIL stall_windows: got %0d windows, mismatch idx %0d, want 6 and none", obs_q.size(), bad);
      end
      checks++;
      if (se_obs != 0 || fd_obs != 1) begin
         errors++;
         $display("FAIL stall_pulses: got se=%0d fd=%0d, want 0 1", se_obs, fd_obs);
      end
   endtask

   task automatic test_sync_err();
      bit ok;
      int bad;
      new_scenario();
      send_range(0, 0, 1, 2, 1'b1);
      send(1, 4, 14);
      checks++;
      if (sync_err !== 1'b1) begin
         errors++;
         $display("FAIL sync_err_pulse: got %b, want 1", sync_err);
      end
      send_range(1, 3, 3, 4, 1'b1);
      drain(ok);
      bad = first_bad();
      checks++;
      if (se_obs != se_exp || se_obs != 1) begin
         errors++;
         $display("FAIL sync_err_count: got %0d pulses, want %0d", se_obs, se_exp);
      end
      checks++;
      if (!ok || bad != -1 || obs_q.size() != 6 || fd_obs != 1) begin
         errors++;
         $display("FAIL sync_resume: got %0d windows fd=%0d mismatch idx %0d, want 6 fd=1 none",
                  obs_q.size(), fd_obs, bad);
      end
   endtask

   task automatic test_restart();
      bit ok;
      int bad;
      new_scenario();
      rdy_mode = 1;
      send_range(0, 0, 2, 1, 1'b1);
      send(0, 0, int'($urandom_range(0, 255)));
      checks++;
      if (sync_err !== 1'b0) begin
         errors++;
         $display("FAIL restart_no_err: got sync_err=%b, want 0", sync_err);
      end
      send_range(0, 1, 3, 4, 1'b1);
      drain(ok);
      bad = first_bad();
      checks++;
      if (!ok || bad != -1 || obs_q.size() != 6) begin
         errors++;
         $display("FAIL restart_windows: got %0d windows, mismatch idx %0d, want 6 and none", obs_q.size(), bad);
      end
      checks++;
      if (se_obs != 0 || fd_obs != 1) begin
         errors++;
         $display("FAIL restart_pulses: got se=%0d fd=%0d, want 0 1", se_obs, fd_obs);
      end
   endtask

   task automatic test_midreset();
      bit ok;
      int bad;
      new_scenario();
      send_range(0, 0, 3, 2, 1'b0);
      do_reset();
      checks++;
      if (win_valid !== 1'b0 || win_data !== '0 || win_row !== '0 || win_col !== '0 ||
          frame_done !== 1'b0 || sync_err !== 1'b0) begin
         errors++;
         $display("FAIL midreset_clear: got v=%b d=%h (%0d,%0d) fd=%b se=%b, want all 0",
                  win_valid, win_data, win_row, win_col, frame_done, sync_err);
      end
      send_range(0, 0, 3, 4, 1'b0);
      drain(ok);
      bad = first_bad();
      checks++;
      if (!ok || bad != -1 || obs_q.size() != 10) begin
         errors++;
         $display("FAIL midreset_windows: got %0d windows, mismatch idx %0d, want 10 and none", obs_q.size(), bad);
      end
      checks++;
      if (se_obs != 0 || fd_obs != 1) begin
         errors++;
         $display("FAIL midreset_pulses: got se=%0d fd=%0d, want 0 1", se_obs, fd_obs);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int bad;
      new_scenario();
      rdy_mode = 1;
      send_range(0, 0, 3, 4, 1'b1);
      send_range(0, 0, 3, 4, 1'b1);
      drain(ok);
      bad = first_bad();
      checks++;
      if (!ok || obs_q.size() != 12) begin
         errors++;
         $display("FAIL b2b_count: got %0d windows, want 12", obs_q.size());
      end
      checks++;
      if (bad != -1) begin
         errors++;
         $display("FAIL b2b_windows: got first mismatch at index %0d, want none", bad);
      end
      checks++;
      if (fd_obs != 2 || se_obs != 0) begin
         errors++;
         $display("FAIL b2b_pulses: got fd=%0d se=%0d, want 2 0", fd_obs, se_obs);
      end
   endtask

   initial begin
      rdy_mode = 0;
      in_valid = 1'b0;
      HRESETn  = 1'b1;
      test_reset();
      test_full_frame();
      test_backpressure();
      test_sync_err();
      do_reset();
      test_restart();
      do_reset();
      test_midreset();
      do_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
